rtc_read_scheduler: RTL and testbench

RTC_READ_SCHEDULER -- requirements
Module: rtc_read_scheduler

---
 rtl/rtc_read_scheduler.sv | 125 ++++++++++++
 tb/tb_rtc_read_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_read_scheduler.sv
// Reads nine RTC registers into a shadow bank (2 cycles from tick to first bus_req, then REQ+WAIT per byte)
// and commits the whole bank to display_bcd at the next frame_end; a read that goes unacknowledged for TIMEOUT_CYC cycles aborts the burst.
module rtc_read_scheduler #(
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [71:0] ADDR_LIST   = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43}
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        tick_read,
    input  logic        frame_end,
    output logic        bus_req,
    output logic [7:0]  bus_addr,
    input  logic        bus_ack,
    input  logic [7:0]  bus_data,
    output logic [71:0] display_bcd,
    output logic        busy,
    output logic        update_done,
    output logic        rd_error
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic [7:0]  addr_q, addr_d;
    logic [71:0] shadow_q, shadow_d;
    logic [71:0] disp_q, disp_d;
    logic        err_q, err_d;

    function automatic logic [7:0] bcd_clean(input logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 8'h00;
        return b;
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        addr_d   = addr_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (tick_read) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // ADDR_LIST is written idx 0 first, so idx 0 sits in the top byte
                for (int i = 0; i < 9; i++) begin
                    if (idx_q == 4'(i)) addr_d = ADDR_LIST[8*(8-i) +: 8];
                end
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus_ack) begin
                    for (int i = 0; i < 9; i++) begin
                        if (idx_q == 4'(i)) shadow_d[8*i +: 8] = bcd_clean(bus_data);
                    end
                    req_d = 1'b0;
                    if (idx_q == 4'd8) begin
                        state_d = HOLD;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = REQ;
                    end
                end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                    // this is the TIMEOUT_CYC-th cycle without an ack
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    shadow_d = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (frame_end) state_d = COMMIT;
            end
            COMMIT: begin
                disp_d  = shadow_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            addr_q   <= 8'h00;
            shadow_q <= '0;
            disp_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            err_q    <= err_d;
        end
    end

    assign bus_req     = req_q;
    assign bus_addr    = addr_q;
    assign display_bcd = disp_q;
    assign busy        = (state_q != IDLE);
    assign update_done = (state_q == COMMIT);
    assign rd_error    = err_q;

endmodule

// File: tb/tb_rtc_read_scheduler.sv
// Self-checking bench: acts as the RTC bus driver and compares against a byte-level model of the committed display.
module tb_rtc_read_scheduler;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        tick_read;
    logic        frame_end;
    logic        bus_ack;
    logic [7:0]  bus_data;
    logic        bus_req;
    logic [7:0]  bus_addr;
    logic [71:0] display_bcd;
    logic        busy;
    logic        update_done;
    logic        rd_error;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [71:0] model_disp = '0;

    localparam logic [7:0] EXP_ADDR [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    rtc_read_scheduler dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .tick_read   (tick_read),
        .frame_end   (frame_end),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_ack     (bus_ack),
        .bus_data    (bus_data),
        .display_bcd (display_bcd),
        .busy        (busy),
        .update_done (update_done),
        .rd_error    (rd_error)
    );

    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, required finish within 900000 ns");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] bcd_or_zero(input logic [7:0] b);
        int v;
        v = int'(b);
        if ((v / 16) < 10 && (v % 16) < 10) return b;
        return 8'h00;
    endfunction

    function automatic logic [71:0] expect_disp(input logic [7:0] d [9]);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[8*i +: 8] = bcd_or_zero(d[i]);
        return r;
    endfunction

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return 8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9));
    endfunction

    task automatic drive_noise(input bit noise);
        if (noise) begin
            tick_read = 1'($urandom_range(0, 1));
            frame_end = 1'($urandom_range(0, 1));
        end
    endtask

    // Pulse tick_read and report how many cycles pass until bus_req is seen.
    task automatic start_burst(output int lat);
        tick_read = 1'b1;
        @(negedge CLK);
        tick_read = 1'b0;
        lat = 1;
        while (bus_req !== 1'b1 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    // Bus-driver role: serve n reads, acking read i after dly[i] extra cycles.
    task automatic serve(input int n, input logic [7:0] d [9], input int dly [9], input bit noise,
                         output logic [7:0] a [9], output int served, output int unstable);
        int w;
        served   = 0;
        unstable = 0;
        for (int i = 0; i < 9; i++) a[i] = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (bus_req !== 1'b1 && w < 40) begin
                @(negedge CLK);
                drive_noise(noise);
                w++;
            end
            if (bus_req !== 1'b1) return;
            a[i] = bus_addr;
            for (int k = 0; k < dly[i]; k++) begin
                @(negedge CLK);
                drive_noise(noise);
                if (bus_req !== 1'b1 || bus_addr !== a[i]) unstable++;
            end
            bus_ack  = 1'b1;
            bus_data = d[i];
            drive_noise(noise);
            @(negedge CLK);
            bus_ack   = 1'b0;
            bus_data  = 8'($urandom);
            tick_read = 1'b0;
            frame_end = 1'b0;
            served++;
        end
    endtask

    // Pulse frame_end and count update_done pulses over the following cycles.
    task automatic pulse_frame_end(output int pulses);
        pulses = 0;
        frame_end = 1'b1;
        @(negedge CLK);
        frame_end = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (update_done === 1'b1) pulses++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; tick_read = 1'b0; frame_end = 1'b0; bus_ack = 1'b0; bus_data = 8'h00;
        repeat (3) @(negedge CLK);
        n_tests++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b required 0", bus_req); end
        n_tests++; if (bus_addr !== 8'h00) begin n_fail++; $display("FAIL reset_bus_addr: got %h required 00", bus_addr); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_tests++; if (update_done !== 1'b0) begin n_fail++; $display("FAIL reset_update_done: got %b required 0", update_done); end
        n_tests++; if (rd_error !== 1'b0) begin n_fail++; $display("FAIL reset_rd_error: got %b required 0", rd_error); end
        n_tests++; if (display_bcd !== 72'h0) begin n_fail++; $display("FAIL reset_display: got %h required 0", display_bcd); end
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        n_tests++; if (busy !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b req=%b required 0/0", busy, bus_req); end
    endtask

    task automatic test_spec_burst();
        logic [7:0] d [9]; int dly [9]; logic [7:0] a [9];
        int lat, served, unstable, p;
        for (int i = 0; i < 9; i++) begin d[i] = 8'h10 + 8'(i); dly[i] = 1; end
        start_burst(lat);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL tick_to_req_latency: got %0d required 2", lat); end
        serve(9, d, dly, 1'b0, a, served, unstable);
        n_tests++; if (served !== 9) begin n_fail++; $display("FAIL spec_served: got %0d required 9", served); end
        for (int i = 0; i < 9; i++) begin
            n_tests++; if (a[i] !== EXP_ADDR[i]) begin n_fail++; $display("FAIL spec_addr[%0d]: got %h required %h", i, a[i], EXP_ADDR[i]); end
        end
        n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL spec_wait_stable: got %0d glitches required 0", unstable); end
        n_tests++; if (busy !== 1'b1 || display_bcd !== model_disp) begin n_fail++; $display("FAIL spec_hold: got busy=%b disp=%h required 1/%h", busy, display_bcd, model_disp); end
        pulse_frame_end(p);
        n_tests++; if (p !== 1) begin n_fail++; $display("FAIL spec_update_pulse: got %0d pulses required 1", p); end
        model_disp = expect_disp(d);
        n_tests++; if (display_bcd !== 72'h18_17_16_15_14_13_12_11_10) begin n_fail++; $display("FAIL spec_display: got %h required 181716151413121110", display_bcd); end
    endtask

    task automatic test_hold_without_frame_end();
        logic [7:0] d [9]; int dly [9]; logic [7:0] a [9];
        int lat, served, unstable, p, bad;
        for (int i = 0; i < 9; i++) begin d[i] = rand_byte(); dly[i] = $urandom_range(0, 3); end
        start_burst(lat);
        serve(9, d, dly, 1'b1, a, served, unstable);
        n_tests++; if (served !== 9) begin n_fail++; $display("FAIL hold_served: got %0d required 9", served); end
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (busy !== 1'b1 || display_bcd !== model_disp || update_done !== 1'b0) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL hold_100_cycles: got %0d bad cycles required 0", bad); end
        pulse_frame_end(p);
        model_disp = expect_disp(d);
        n_tests++; if (p !== 1) begin n_fail++; $display("FAIL hold_update_pulse: got %0d pulses required 1", p); end
        n_tests++; if (display_bcd !== model_disp) begin n_fail++; $display("FAIL hold_commit: got %h required %h", display_bcd, model_disp); end
    endtask

    task automatic test_timeout();
        logic [7:0] d [9]; int dly [9]; logic [7:0] a [9];
        int lat, served, unstable, p, w, hi;
        for (int i = 0; i < 9; i++) begin d[i] = rand_byte(); dly[i] = $urandom_range(0, 2); end
        start_burst(lat);
        serve(3, d, dly, 1'b1, a, served, unstable);
        w = 0;
        while (bus_req !== 1'b1 && w < 40) begin @(negedge CLK); w++; end
        hi = 0;
        while (bus_req === 1'b1 && hi < 400) begin hi++; @(negedge CLK); end
        n_tests++; if (hi !== 255) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d required 255", hi); end
        n_tests++; if (rd_error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_flags: got err=%b busy=%b required 1/0", rd_error, busy); end
        pulse_frame_end(p);
        n_tests++; if (p !== 0 || display_bcd !== model_disp) begin n_fail++; $display("FAIL timeout_no_commit: got %0d pulses disp=%h required 0/%h", p, display_bcd, model_disp); end
        n_tests++; if (rd_error !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b required 1", rd_error); end
        start_burst(lat);
        n_tests++; if (rd_error !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL timeout_clear: got err=%b lat=%0d required 0/2", rd_error, lat); end
        serve(9, d, dly, 1'b0, a, served, unstable);
        pulse_frame_end(p);
        model_disp = expect_disp(d);
        n_tests++; if (display_bcd !== model_disp) begin n_fail++; $display("FAIL timeout_recover: got %h required %h", display_bcd, model_disp); end
    endtask

    task automatic test_invalid_bcd();
        logic [7:0] d [9]; int dly [9]; logic [7:0] a [9];
        int lat, served, unstable, p;
        for (int i = 0; i < 9; i++) begin d[i] = 8'(($urandom_range(0, 9) << 4) | $urandom_range(1, 9)); dly[i] = $urandom_range(0, 2); end
        d[0] = 8'h5A;
        d[4] = 8'hA3;
        start_burst(lat);
        serve(9, d, dly, 1'b0, a, served, unstable);
        pulse_frame_end(p);
        model_disp = expect_disp(d);
        n_tests++; if (display_bcd[7:0] !== 8'h00) begin n_fail++; $display("FAIL bcd_byte0: got %h required 00", display_bcd[7:0]); end
        n_tests++; if (display_bcd[15:8] !== d[1]) begin n_fail++; $display("FAIL bcd_byte1: got %h required %h", display_bcd[15:8], d[1]); end
        n_tests++; if (display_bcd !== model_disp) begin n_fail++; $display("FAIL bcd_display: got %h required %h", display_bcd, model_disp); end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] d [9]; int dly [9]; logic [7:0] a [9];
        int lat, served, unstable, p, w;
        for (int i = 0; i < 9; i++) begin d[i] = rand_byte(); dly[i] = $urandom_range(0, 2); end
        start_burst(lat);
        serve(5, d, dly, 1'b0, a, served, unstable);
        w = 0;
        while (bus_req !== 1'b1 && w < 40) begin @(negedge CLK); w++; end
        n_tests++; if (bus_addr !== 8'h26) begin n_fail++; $display("FAIL rst_mid_addr: got %h required 26", bus_addr); end
        #2 RESET = 1'b1;
        #1;
        n_tests++; if (bus_req !== 1'b0 || display_bcd !== 72'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async: got req=%b disp=%h busy=%b required 0/0/0", bus_req, display_bcd, busy); end
        @(negedge CLK);
        RESET = 1'b0;
        model_disp = '0;
        repeat (3) @(negedge CLK);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got busy=%b required 0", busy); end
        start_burst(lat);
        n_tests++; if (bus_addr !== 8'h21 || lat !== 2) begin n_fail++; $display("FAIL rst_restart: got addr=%h lat=%0d required 21/2", bus_addr, lat); end
        serve(9, d, dly, 1'b1, a, served, unstable);
        pulse_frame_end(p);
        model_disp = expect_disp(d);
        n_tests++; if (display_bcd !== model_disp) begin n_fail++; $display("FAIL rst_restart_commit: got %h required %h", display_bcd, model_disp); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [9]; int dly [9]; logic [7:0] a [9];
        int lat, served, unstable, k, abad;
        k = $urandom_range(0, 8);
        for (int i = 0; i < 9; i++) begin d[i] = rand_byte(); dly[i] = 0; end
        dly[k] = 254;
        start_burst(lat);
        serve(9, d, dly, 1'b1, a, served, unstable);
        abad = 0;
        for (int i = 0; i < 9; i++) if (a[i] !== EXP_ADDR[i]) abad++;
        n_tests++; if (served !== 9 || unstable !== 0 || abad !== 0) begin n_fail++; $display("FAIL b2b_burst: got served=%0d glitches=%0d badaddr=%0d required 9/0/0", served, unstable, abad); end
        n_tests++; if (rd_error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_ack_at_timeout: got err=%b busy=%b required 0/1", rd_error, busy); end
        frame_end = 1'b1;
        @(negedge CLK);
        frame_end = 1'b0;
        n_tests++; if (update_done !== 1'b1) begin n_fail++; $display("FAIL b2b_update_done: got %b required 1", update_done); end
        tick_read = 1'b1;
        @(negedge CLK);
        tick_read = 1'b0;
        model_disp = expect_disp(d);
        n_tests++; if (display_bcd !== model_disp) begin n_fail++; $display("FAIL b2b_commit: got %h required %h", display_bcd, model_disp); end
        repeat (2) @(negedge CLK);
        n_tests++; if (busy !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL b2b_tick_not_queued: got busy=%b req=%b required 0/0", busy, bus_req); end
    endtask

    task automatic test_random_bursts();
        logic [7:0] d [9]; int dly [9]; logic [7:0] a [9];
        int lat, served, unstable, p, abad;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 9; i++) begin d[i] = rand_byte(); dly[i] = $urandom_range(0, 5); end
            start_burst(lat);
            serve(9, d, dly, 1'b1, a, served, unstable);
            abad = 0;
            for (int i = 0; i < 9; i++) if (a[i] !== EXP_ADDR[i]) abad++;
            n_tests++; if (abad !== 0 || unstable !== 0) begin n_fail++; $display("FAIL rand_addr[%0d]: got badaddr=%0d glitches=%0d required 0/0", r, abad, unstable); end
            pulse_frame_end(p);
            model_disp = expect_disp(d);
            n_tests++; if (p !== 1 || display_bcd !== model_disp) begin n_fail++; $display("FAIL rand_commit[%0d]: got %0d pulses disp=%h required 1/%h", r, p, display_bcd, model_disp); end
        end
    endtask

    initial begin
        test_reset();
        test_spec_burst();
        test_hold_without_frame_end();
        test_timeout();
        test_invalid_bcd();
        test_reset_mid_burst();
        test_back_to_back();
        test_random_bursts();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
